freq_prescaler: RTL and testbench
=================================

// Module: freq_prescaler
// PURPOSE
//  Clocked, multi-decade prescaler for the frequency meter front end. It
//  synchronises the raw input signal, counts its rising edges through a
//  cascade of STAGES divide-by-RATIO counters, and selects one decade by range.
//  The result drives the gate/count logic as a divided square wave plus a
//  one-cycle tick.
// PARAMETERS
//  RATIO    10  divide factor per stage; must be >= 2
//  STAGES   3   number of cascaded stages; highest division is RATIO^STAGES
//  CNT_W    4   stage counter width; RATIO-1 must fit in CNT_W bits
//  RANGE_W  2   range select width; 2^RANGE_W must be >= STAGES+1
// PORTS
//  clk         in   1        system clock; all state changes on its rising edge
//  reset       in   1        asynchronous, active-high reset
//  signal      in   1        asynchronous input to be measured
//  range       in   RANGE_W  0 = pass-through, k = divide by RATIO^k; k > STAGES clamps to STAGES
//  new_signal  out  1        divided square wave (range 0: synchronised copy of signal)
//  tick        out  1        one-clk pulse every RATIO^k rising edges (range 0: every rising edge)
//  valid       out  1        new_signal/tick are consistent with the current range
// BEHAVIOUR
//  Reset (async, active-high):
//  - sync flops, edge flop, all stage counters, new_signal, tick and valid go to 0.
//  - range_q (registered range) goes to 0.
//  Input path:
//  - signal passes through a 2-flop synchroniser (s1, s2), then s3 <= s2.
//  - edge_p = s2 & ~s3 (combinational).
//  Input limits:
//  - signal high and low phases must each be >= 2 clk periods; faster input is out of spec.
//  Stage cascade:
//  - stage 1 counts edge_p; stage j counts carry(j-1).
//  - carry(j) = stage j input pulse while its count == RATIO-1; the count then wraps to 0.
//  - Carries ripple within one cycle.
//  - Each count is in 0..RATIO-1 and is never held at RATIO.
//  Range resolution:
//  - eff = min(range, STAGES); range_q <= eff every cycle.
//  - sel_pulse = edge_p when eff == 0, else carry(eff).
//  Outputs, all registered:
//  - tick <= sel_pulse.
//  - range 0: new_signal <= s2.
//  - range k >= 1: new_signal toggles on every sel_pulse, so f_out = f_in / (2*RATIO^k).
//    Downstream logic applies the factor of 2.
//  Latency:
//  - The first clk edge that samples signal high is edge 1.
//  - tick and new_signal update at edge 3 (3 clk) for every range.
//  Range change (eff != range_q), in the same cycle:
//  - all stage counters clear to 0 and new_signal <= 0.
//  - tick <= 0 and valid <= 0.
//  - Any edge_p in that cycle is discarded.
//  valid:
//  - sets on the first tick after reset or a range change.
//  - stays set until the next range change or reset.
//  Other boundaries:
//  - All stages wrap in the same cycle (RATIO^STAGES edges): a single tick, with no lost or extra count.
//  - Reset mid-count: counters restart from 0 with no residual tick.
// TESTING
//  1. range=0, 5 slow pulses -> new_signal follows signal 3 clk late; 5 ticks; valid=1 after the 1st.
//  2. range=1, RATIO=10, 20 rising edges -> ticks after edges 10 and 20; new_signal high after 10, low after 20.
//  3. range=3, 1000 edges -> exactly 1 tick at edge 1000, 3 clk after that edge is sampled; stage counts all 0.
//  4. range=2, 57 edges, then range=1 -> valid=0 and counters 0; ticks after 10 further edges; valid=1.
//  5. range=3 (2'b11) with STAGES=2 -> behaves as range 2: tick every 100 edges.
//  6. reset asserted mid-count at range 1 (edge 7) -> all outputs 0 at once; after release, next tick at 10 new edges.

Source files
------------

// File: rtl/freq_prescaler.sv
// Multi-decade input prescaler: synchronises signal, counts its rising edges
// through STAGES divide-by-RATIO counters and emits the decade chosen by range.
module freq_prescaler #(
  parameter int unsigned RATIO   = 10,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned RANGE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               signal,
  input  logic [RANGE_W-1:0] range,
  output logic               new_signal,
  output logic               tick,
  output logic               valid
);

  localparam int unsigned        SEL_N   = 2 ** RANGE_W;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(RATIO - 1);
  localparam logic [RANGE_W-1:0] EFF_MAX = RANGE_W'(STAGES);

  logic               s1_q, s2_q, s3_q;
  logic [RANGE_W-1:0] range_q;
  logic               new_signal_q, new_signal_d;
  logic               tick_q, tick_d;
  logic               valid_q, valid_d;

  logic [RANGE_W-1:0] eff_c;
  logic               chg_c;
  logic               edge_c;
  logic [STAGES-1:0]  at_max_c;
  logic [STAGES:0]    stage_in_c;
  logic [SEL_N-1:0]   sel_vec_c;
  logic               sel_c;

  // Range clamp, change detect and input edge
  assign eff_c  = (range > EFF_MAX) ? EFF_MAX : range;
  assign chg_c  = (eff_c != range_q);
  assign edge_c = s2_q & ~s3_q;

  // Edges arriving in a range-change cycle are dropped
  assign stage_in_c[0] = edge_c & ~chg_c;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_max_c[g]     = (cnt_q == CNT_MAX);
    // Carry computed from the AND of lower stages so the ripple is flat
    assign stage_in_c[g+1] = stage_in_c[0] & (&at_max_c[g:0]);

    always_comb begin
      cnt_d = cnt_q;
      if (chg_c) begin
        cnt_d = '0;
      end else if (stage_in_c[g]) begin
        cnt_d = at_max_c[g] ? '0 : cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

  assign sel_vec_c = SEL_N'(stage_in_c);
  assign sel_c     = sel_vec_c[eff_c];

  // Output next-state
  always_comb begin
    tick_d       = 1'b0;
    valid_d      = valid_q;
    new_signal_d = new_signal_q;
    if (chg_c) begin
      valid_d      = 1'b0;
      new_signal_d = 1'b0;
    end else begin
      tick_d  = sel_c;
      valid_d = valid_q | sel_c;
      if (eff_c == '0)  new_signal_d = s2_q;
      else if (sel_c)   new_signal_d = ~new_signal_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      range_q      <= '0;
      new_signal_q <= 1'b0;
      tick_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      s1_q         <= signal;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      range_q      <= eff_c;
      new_signal_q <= new_signal_d;
      tick_q       <= tick_d;
      valid_q      <= valid_d;
    end
  end

  assign new_signal = new_signal_q;
  assign tick       = tick_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_freq_prescaler.sv
// Scoreboard bench for freq_prescaler: a 3-stage instance and a 2-stage
// instance (range clamping) share the input; ticks are checked against a model.
module tb_freq_prescaler;

  localparam int unsigned RATIO = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       signal = 1'b0;
  logic [1:0] range_a = 2'd0, range_b = 2'd0;
  logic       ns_a, tick_a, valid_a;
  logic       ns_b, tick_b, valid_b;

  freq_prescaler #(.RATIO(RATIO), .STAGES(3), .CNT_W(4), .RANGE_W(2)) dut_a (
    .clk(clk), .reset(reset), .signal(signal), .range(range_a),
    .new_signal(ns_a), .tick(tick_a), .valid(valid_a));

  freq_prescaler #(.RATIO(RATIO), .STAGES(2), .CNT_W(4), .RANGE_W(2)) dut_b (
    .clk(clk), .reset(reset), .signal(signal), .range(range_b),
    .new_signal(ns_b), .tick(tick_b), .valid(valid_b));

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic ns;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic chk_follow = 1'b0;
  logic [2:0] sig_h = '0;

  // Model state, index 0 = dut_a (3 stages), 1 = dut_b (2 stages)
  int   ecnt [2];
  int   eff_m [2];
  logic ns_m [2];
  int   stg_m [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: each tick pops and matches one scoreboard entry
  always @(negedge clk) begin
    if (!reset) begin
      if (tick_a) begin
        if (q_a.size() == 0) check_eq("a_spurious_tick", 32'(tick_a), 32'd0);
        else begin
          e_a = q_a.pop_front();
          check_eq("a_tick_cycle", 32'(cyc), 32'(e_a.cyc));
          check_eq("a_tick_new_signal", 32'(ns_a), 32'(e_a.ns));
          check_eq("a_tick_valid", 32'(valid_a), 32'd1);
        end
      end
      if (tick_b) begin
        if (q_b.size() == 0) check_eq("b_spurious_tick", 32'(tick_b), 32'd0);
        else begin
          e_b = q_b.pop_front();
          check_eq("b_tick_cycle", 32'(cyc), 32'(e_b.cyc));
          check_eq("b_tick_new_signal", 32'(ns_b), 32'(e_b.ns));
          check_eq("b_tick_valid", 32'(valid_b), 32'd1);
        end
      end
      if (chk_follow) check_eq("a_follow_3clk", 32'(ns_a), 32'(sig_h[2]));
    end
    sig_h <= {sig_h[1:0], signal};
  end

  function automatic int eff_of(input int r, input int st);
    return (r > st) ? st : r;
  endfunction

  function automatic int pow_ratio(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * RATIO;
    return p;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One rising edge on signal; model predicts any tick due from it
  task automatic pulse();
    exp_t e;
    signal = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ecnt[d]++;
      if (ecnt[d] % pow_ratio(eff_m[d]) == 0) begin
        ns_m[d] = (eff_m[d] == 0) ? 1'b1 : ~ns_m[d];
        e.cyc = cyc + 3;
        e.ns  = ns_m[d];
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
    end
    wait_cyc(3);
    signal = 1'b0;
    wait_cyc(3);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic set_range(input logic [1:0] ra, input logic [1:0] rb);
    logic chg [2];
    int   ne;
    range_a = ra;
    range_b = rb;
    for (int d = 0; d < 2; d++) begin
      ne = eff_of(int'(d == 0 ? ra : rb), stg_m[d]);
      chg[d] = (ne != eff_m[d]);
      if (chg[d]) begin
        eff_m[d] = ne;
        ecnt[d]  = 0;
        ns_m[d]  = 1'b0;
      end
    end
    wait_cyc(1);
    if (chg[0]) begin
      check_eq("a_chg_valid", 32'(valid_a), 32'd0);
      check_eq("a_chg_new_signal", 32'(ns_a), 32'd0);
      check_eq("a_chg_tick", 32'(tick_a), 32'd0);
    end
    if (chg[1]) begin
      check_eq("b_chg_valid", 32'(valid_b), 32'd0);
      check_eq("b_chg_new_signal", 32'(ns_b), 32'd0);
    end
  endtask

  task automatic check_drained(input string tag);
    wait_cyc(4);
    check_eq({tag, "_a_pending"}, 32'(q_a.size()), 32'd0);
    check_eq({tag, "_b_pending"}, 32'(q_b.size()), 32'd0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ecnt[d]  = 0;
      ns_m[d]  = 1'b0;
      eff_m[d] = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stg_m[0] = 3;
    stg_m[1] = 2;
    model_reset();
    wait_cyc(3);
    check_eq("rst_new_signal", 32'(ns_a), 32'd0);
    check_eq("rst_tick", 32'(tick_a), 32'd0);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_b_valid", 32'(valid_b), 32'd0);
    reset = 1'b0;
    wait_cyc(4);

    // Range 0: pass-through, new_signal follows signal 3 clk late
    check_eq("r0_valid_before", 32'(valid_a), 32'd0);
    chk_follow = 1'b1;
    pulses(5);
    chk_follow = 1'b0;
    check_eq("r0_valid_after", 32'(valid_a), 32'd1);
    check_drained("r0");

    // Range 1: ticks at edges 10 and 20, new_signal toggles
    set_range(2'd1, 2'd1);
    pulses(20);
    check_eq("r1_new_signal_low", 32'(ns_a), 32'd0);
    check_drained("r1");

    // Range 3: one tick at edge 1000; dut_b clamps 3 -> 2 (tick every 100)
    set_range(2'd3, 2'd3);
    pulses(1000);
    check_eq("r3_new_signal", 32'(ns_a), 32'd1);
    check_eq("r3_b_new_signal", 32'(ns_b), 32'd0);
    check_drained("r3");

    // Range 2 part-way, then switch to range 1
    set_range(2'd2, 2'd2);
    pulses(57);
    set_range(2'd1, 2'd1);
    pulses(10);
    check_eq("r2to1_valid", 32'(valid_a), 32'd1);
    check_drained("r2to1");

    // Reset mid-count at range 1
    pulses(7);
    reset = 1'b1;
    #3;
    check_eq("midrst_new_signal", 32'(ns_a), 32'd0);
    check_eq("midrst_tick", 32'(tick_a), 32'd0);
    check_eq("midrst_valid", 32'(valid_a), 32'd0);
    check_eq("midrst_b_valid", 32'(valid_b), 32'd0);
    model_reset();
    wait_cyc(2);
    reset = 1'b0;
    eff_m[0] = 1;
    eff_m[1] = 1;
    wait_cyc(2);
    check_eq("postrst_valid", 32'(valid_a), 32'd0);
    pulses(9);
    check_eq("postrst_no_tick_yet", 32'(q_a.size()), 32'd0);
    pulses(1);
    check_drained("postrst");
    check_eq("postrst_valid_set", 32'(valid_a), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
